line_list_sequencer: RTL and testbench

//  Frame-level controller for the line-drawing engine (draw_lines). On each start request it

---
 rtl/line_list_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_line_list_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_list_sequencer.sv
// line_list_sequencer
//   Frame-level controller for the draw_lines engine. A start request clears
//   the engine's frame buffer and then walks the line list in external
//   memory, handing one segment at a time to the engine. The next segment is
//   not issued until the engine reports idle again.
//
// Ports
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_start               frame request pulse (accepted only when idle)
//   i_num_lines           segment count, latched on an accepted start
//   o_line_addr           line-list read address (data returns one cycle later)
//   i_line_x0..i_line_y1  segment endpoints from the list memory
//   o_x0..o_y1            registered endpoints presented to the engine
//   o_load_vals           one-cycle pulse: engine starts drawing o_x0..o_y1
//   o_clear_buffer        one-cycle pulse: engine clears its frame buffer
//   i_engine_waiting      engine idle (1) / busy (0)
//   o_busy                high from accepted start until the done pulse
//   o_frame_done          one-cycle pulse when all segments are drawn
//   o_start_missed        one-cycle pulse, one cycle after a start that
//                         arrived while a frame was in progress
//   o_dbg_state           current FSM state, for observation only
//
// Engine handshake: o_load_vals / o_clear_buffer are single-cycle commands.
// The engine may take a few cycles to drop i_engine_waiting after a command,
// so the input is ignored for GUARD cycles after each command; after that a
// high i_engine_waiting means the command has completed. A busy engine
// stalls the sequencer without any timeout.
module line_list_sequencer #(
  parameter int COORD_W   = 11,
  parameter int MAX_LINES = 12,
  parameter int GUARD     = 2,
  localparam int IDX_W    = $clog2(MAX_LINES)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [IDX_W:0]     i_num_lines,
  output logic [IDX_W-1:0]   o_line_addr,
  input  logic [COORD_W-1:0] i_line_x0,
  input  logic [COORD_W-1:0] i_line_y0,
  input  logic [COORD_W-1:0] i_line_x1,
  input  logic [COORD_W-1:0] i_line_y1,
  output logic [COORD_W-1:0] o_x0,
  output logic [COORD_W-1:0] o_y0,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_y1,
  output logic               o_load_vals,
  output logic               o_clear_buffer,
  input  logic               i_engine_waiting,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_start_missed,
  output logic [2:0]         o_dbg_state
);

  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
  localparam logic [GW-1:0]  GUARD_V = GW'(GUARD);
  localparam logic [IDX_W:0] MAX_N   = (IDX_W + 1)'(MAX_LINES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_CLR_WAIT  = 3'd2,
    S_FETCH     = 3'd3,
    S_READ      = 3'd4,
    S_ISSUE     = 3'd5,
    S_DRAW_WAIT = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t               state_q;
  logic [IDX_W:0]       n_q;
  logic [IDX_W-1:0]     idx_q;
  logic [GW-1:0]        guard_q;
  logic [IDX_W-1:0]     addr_q;
  logic [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q;
  logic                 load_q, clear_q, done_q, busy_q, missed_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      idx_q    <= '0;
      guard_q  <= '0;
      addr_q   <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      load_q   <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      // Pulse outputs are set on entry to their state and drop one cycle later.
      load_q   <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      // Starts are accepted only in IDLE; anything else (including DONE) is missed.
      missed_q <= i_start && (state_q != S_IDLE);

      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            n_q     <= (i_num_lines > MAX_N) ? MAX_N : i_num_lines;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            clear_q <= 1'b1;
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          guard_q <= GUARD_V;
          state_q <= S_CLR_WAIT;
        end
        S_CLR_WAIT: begin
          if (guard_q != '0) begin
            guard_q <= guard_q - 1'b1;
          end else if (i_engine_waiting) begin
            if (n_q == '0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              addr_q  <= '0;
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Address is already on o_line_addr; memory data lands during READ.
          state_q <= S_READ;
        end
        S_READ: begin
          x0_q    <= i_line_x0;
          y0_q    <= i_line_y0;
          x1_q    <= i_line_x1;
          y1_q    <= i_line_y1;
          load_q  <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          guard_q <= GUARD_V;
          state_q <= S_DRAW_WAIT;
        end
        S_DRAW_WAIT: begin
          if (guard_q != '0) begin
            guard_q <= guard_q - 1'b1;
          end else if (i_engine_waiting) begin
            // n_q >= 1 here, so n_q - 1 cannot underflow.
            if ({1'b0, idx_q} == (n_q - 1'b1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              addr_q  <= idx_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_line_addr    = addr_q;
  assign o_x0           = x0_q;
  assign o_y0           = y0_q;
  assign o_x1           = x1_q;
  assign o_y1           = y1_q;
  assign o_load_vals    = load_q;
  assign o_clear_buffer = clear_q;
  assign o_busy         = busy_q;
  assign o_frame_done   = done_q;
  assign o_start_missed = missed_q;
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_line_list_sequencer.sv
module tb_line_list_sequencer;

  localparam int CW    = 11;
  localparam int ML    = 12;
  localparam int GUARD = 2;
  localparam int IDX_W = 4;
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd5;
  localparam logic [2:0] ST_DRAW_WAIT = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             start;
  logic [IDX_W:0]   num_lines;
  logic [IDX_W-1:0] line_addr;
  logic [CW-1:0]    lx0, ly0, lx1, ly1;
  logic [CW-1:0]    ox0, oy0, ox1, oy1;
  logic             load, clear, eng_waiting, busy, done, missed;
  logic [2:0]       dbg;

  line_list_sequencer #(.COORD_W(CW), .MAX_LINES(ML), .GUARD(GUARD)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_start          (start),
    .i_num_lines      (num_lines),
    .o_line_addr      (line_addr),
    .i_line_x0        (lx0),
    .i_line_y0        (ly0),
    .i_line_x1        (lx1),
    .i_line_y1        (ly1),
    .o_x0             (ox0),
    .o_y0             (oy0),
    .o_x1             (ox1),
    .o_y1             (oy1),
    .o_load_vals      (load),
    .o_clear_buffer   (clear),
    .i_engine_waiting (eng_waiting),
    .o_busy           (busy),
    .o_frame_done     (done),
    .o_start_missed   (missed),
    .o_dbg_state      (dbg)
  );

  // ---------------- line-list memory (1-cycle read) ----------------
  logic [CW-1:0] mem_x0 [16];
  logic [CW-1:0] mem_y0 [16];
  logic [CW-1:0] mem_x1 [16];
  logic [CW-1:0] mem_y1 [16];

  always @(posedge clk) begin
    lx0 <= mem_x0[line_addr];
    ly0 <= mem_y0[line_addr];
    lx1 <= mem_x1[line_addr];
    ly1 <= mem_y1[line_addr];
  end

  // ---------------- engine model ----------------
  int   busy_len;
  logic eng_stuck;
  int   eng_cnt;

  always @(posedge clk) begin
    if (rst) begin
      eng_waiting <= 1'b1;
      eng_cnt     <= 0;
    end else if (eng_stuck) begin
      eng_waiting <= 1'b0;
    end else if (load || clear) begin
      eng_cnt     <= busy_len;
      eng_waiting <= (busy_len == 0);
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      eng_cnt     <= 0;
      eng_waiting <= 1'b1;
    end
  end

  // ---------------- monitor ----------------
  logic [47:0]   load_val_q[$];
  int            load_cyc_q[$];
  int            clear_cnt = 0;
  int            last_clear_cyc = 0;
  int            done_cnt = 0;
  int            missed_cnt = 0;
  int            coord_bad = 0;
  logic [IDX_W-1:0] max_addr = '0;
  logic [4*CW-1:0]  prev_coords;

  always @(negedge clk) begin
    if (load) begin
      load_val_q.push_back({line_addr, ox0, oy0, ox1, oy1});
      load_cyc_q.push_back(cyc);
    end
    if (clear) begin
      clear_cnt++;
      last_clear_cyc = cyc;
    end
    if (done) done_cnt++;
    if (missed) missed_cnt++;
    if (!rst && line_addr > max_addr) max_addr = line_addr;
    if (!rst && ({ox0, oy0, ox1, oy1} != prev_coords) && dbg != ST_ISSUE) coord_bad++;
    prev_coords = {ox0, oy0, ox1, oy1};
  end

  // ---------------- scoreboard / checking ----------------
  logic [47:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int c0, d0, l0, m0, sc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, {line_addr, ox0, oy0, ox1, oy1, load, clear, busy, done, missed}, 64'd0);
    check({tag, "_state"}, dbg, ST_IDLE);
  endtask

  task automatic start_frame(input int req, input int exp_n);
    c0 = clear_cnt; d0 = done_cnt; l0 = load_val_q.size(); m0 = missed_cnt;
    for (int i = 0; i < exp_n; i++)
      exp_q.push_back({4'(i), mem_x0[i], mem_y0[i], mem_x1[i], mem_y1[i]});
    num_lines = 5'(req);
    start = 1'b1;
    sc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, (done_cnt != d0), 1);
  endtask

  task automatic finish_frame(input string tag, input int exp_n);
    logic [47:0] obs, e;
    wait_done(tag, 3000);
    step();
    check({tag, "_clears"}, clear_cnt - c0, 1);
    check({tag, "_clr_latency"}, last_clear_cyc, sc + 1);
    check({tag, "_loads"}, load_val_q.size() - l0, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      e = exp_q.pop_front();
      obs = (l0 + i < load_val_q.size()) ? load_val_q[l0 + i] : '1;
      check($sformatf("%s_seg%0d", tag, i), obs, e);
    end
    check({tag, "_dones"}, done_cnt - d0, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic wait_loads(input int target, input int budget);
    int k = 0;
    while (load_val_q.size() - l0 < target && k < budget) begin
      step();
      k++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_lines = '0;
    busy_len = 4; eng_stuck = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_x0[i] = 11'($urandom_range(0, 2047));
      mem_y0[i] = 11'($urandom_range(0, 2047));
      mem_x1[i] = 11'($urandom_range(0, 2047));
      mem_y1[i] = 11'($urandom_range(0, 2047));
    end

    // Power-on reset
    repeat (3) step();
    check_all_zero("por");
    rst = 1'b0;
    step();
    check_all_zero("por_idle");

    // T2: three segments from the reference list, engine busy 4 cycles per op
    mem_x0[0] = 11'd0;  mem_y0[0] = 11'd0; mem_x1[0] = 11'd3; mem_y1[0] = 11'd3;
    mem_x0[1] = 11'd5;  mem_y0[1] = 11'd1; mem_x1[1] = 11'd5; mem_y1[1] = 11'd9;
    mem_x0[2] = 11'd10; mem_y0[2] = 11'd2; mem_x1[2] = 11'd1; mem_y1[2] = 11'd2;
    busy_len = 4;
    start_frame(3, 3);
    check("t2_busy_on", busy, 1);
    finish_frame("t2", 3);
    check("t2_no_missed", missed_cnt - m0, 0);

    // T3: zero segments -> clear only
    start_frame(0, 0);
    finish_frame("t3", 0);

    // T4: request above the maximum is clamped
    start_frame(15, 12);
    finish_frame("t4", 12);
    check("t4_max_addr", max_addr, 11);

    // T5: start during DRAW_WAIT of line 1 is missed; num_lines change ignored
    busy_len = 6;
    start_frame(3, 3);
    wait_loads(2, 500);
    check("t5_in_draw_wait", dbg, ST_DRAW_WAIT);
    start = 1'b1;
    num_lines = 5'd12;
    step();
    start = 1'b0;
    step();
    check("t5_missed", missed_cnt - m0, 1);
    check("t5_busy_kept", busy, 1);
    finish_frame("t5", 3);

    // T6: engine reports idle immediately; guard must hold off the next load
    busy_len = 0;
    start_frame(5, 5);
    finish_frame("t6", 5);
    for (int i = 1; i < 5; i++)
      check($sformatf("t6_gap%0d", i),
            ((load_cyc_q[l0 + i] - load_cyc_q[l0 + i - 1]) >= GUARD + 3), 1);
    check("coords_stable", coord_bad, 0);

    // T1: reset while stalled in DRAW_WAIT
    busy_len = 4;
    start_frame(3, 0);
    wait_loads(1, 500);
    eng_stuck = 1'b1;
    repeat (5) step();
    check("t1_stalled_state", dbg, ST_DRAW_WAIT);
    check("t1_stalled_busy", busy, 1);
    rst = 1'b1;
    step();
    step();
    check_all_zero("t1_reset");
    rst = 1'b0;
    eng_stuck = 1'b0;
    repeat (4) step();
    check_all_zero("t1_after");
    check("t1_no_done", done_cnt - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
